// File: rtl/l2_port_arbiter_pkg.sv
// Shared constants for the L2 port arbiter: default geometry, derived widths
// and the requester IDs stored in the outstanding queue.
package l2_port_arbiter_pkg;

    localparam int DEF_L2_BUS_WIDTH    = 64;
    localparam int DEF_BUFFER_WIDTH    = 128;
    localparam int DEF_ADDR_WIDTH      = 32;
    localparam int DEF_MAX_OUTSTANDING = 4;

    localparam int BEATS          = DEF_BUFFER_WIDTH / DEF_L2_BUS_WIDTH;
    localparam int BEAT_CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int QPTR_WIDTH     = $clog2(DEF_MAX_OUTSTANDING);

    typedef logic port_id_t;

    localparam port_id_t PORT_INS  = 1'b0;
    localparam port_id_t PORT_DATA = 1'b1;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Bundle of the two L1 request/response channels and the shared L2 channels.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface l2_port_arbiter_if
    import l2_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int L2_BUS_WIDTH = DEF_L2_BUS_WIDTH
);

    logic                    REQ0_VALID;
    logic                    REQ1_VALID;
    logic [ADDR_WIDTH-1:0]   REQ0_ADDR;
    logic [ADDR_WIDTH-1:0]   REQ1_ADDR;
    logic                    REQ0_READY;
    logic                    REQ1_READY;

    logic                    L2_REQ_VALID;
    logic [ADDR_WIDTH-1:0]   L2_REQ_ADDR;
    logic                    L2_REQ_READY;

    logic                    DATA_FROM_L2_VALID;
    logic [L2_BUS_WIDTH-1:0] DATA_FROM_L2;
    logic                    DATA_FROM_L2_READY;

    logic                    RESP0_VALID;
    logic                    RESP1_VALID;
    logic                    RESP0_READY;
    logic                    RESP1_READY;
    logic [L2_BUS_WIDTH-1:0] RESP_DATA;
    logic                    RESP_LAST;
    logic                    UNEXPECTED_RESP;

    modport slave (
        input  REQ0_VALID, REQ1_VALID, REQ0_ADDR, REQ1_ADDR,
        output REQ0_READY, REQ1_READY,
        output L2_REQ_VALID, L2_REQ_ADDR,
        input  L2_REQ_READY,
        input  DATA_FROM_L2_VALID, DATA_FROM_L2,
        output DATA_FROM_L2_READY,
        output RESP0_VALID, RESP1_VALID,
        input  RESP0_READY, RESP1_READY,
        output RESP_DATA, RESP_LAST, UNEXPECTED_RESP
    );

    modport master (
        output REQ0_VALID, REQ1_VALID, REQ0_ADDR, REQ1_ADDR,
        input  REQ0_READY, REQ1_READY,
        input  L2_REQ_VALID, L2_REQ_ADDR,
        output L2_REQ_READY,
        output DATA_FROM_L2_VALID, DATA_FROM_L2,
        input  DATA_FROM_L2_READY,
        input  RESP0_VALID, RESP1_VALID,
        output RESP0_READY, RESP1_READY,
        input  RESP_DATA, RESP_LAST, UNEXPECTED_RESP
    );

endinterface

// File: rtl/l2_port_arbiter_outstanding_id_fifo.sv
// In-order queue of requester IDs for requests issued to L2 but not yet refilled.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module outstanding_id_fifo
    import l2_port_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_OUTSTANDING,
    parameter int PTR_W = QPTR_WIDTH
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     push_i,
    input  logic     pop_i,
    input  port_id_t id_i,
    output port_id_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    port_id_t     mem_q [DEPTH];
    logic [PTR_W:0] wrPtr_q;
    logic [PTR_W:0] rdPtr_q;
    logic           doPush;
    logic           doPop;

    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign head_o  = mem_q[rdPtr_q[PTR_W-1:0]];

    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem_q[wrPtr_q[PTR_W-1:0]] <= id_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + {{PTR_W{1'b0}}, 1'b1};
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin sharing of one L2 request channel and one L2 return channel
// between the instruction cache (port 0) and the data cache (port 1).
module l2_port_arbiter
    import l2_port_arbiter_pkg::*;
#(
    parameter int L2_BUS_WIDTH    = DEF_L2_BUS_WIDTH,
    parameter int BUFFER_WIDTH    = DEF_BUFFER_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input logic               CLK,
    input logic               RST,
    l2_port_arbiter_if.slave  bus
);

    localparam int NBEATS = BUFFER_WIDTH / L2_BUS_WIDTH;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    logic             lock_q, lock_d;
    port_id_t         lockedId_q, lockedId_d;
    port_id_t         lastGrant_q, lastGrant_d;
    logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
    logic             unexpected_q, unexpected_d;

    port_id_t grant;
    port_id_t head;
    logic     fifoFull;
    logic     fifoEmpty;
    logic     reqValid;
    logic     reqHandshake;
    logic     headReady;
    logic     dataReady;
    logic     beatHandshake;
    logic     lastBeat;

    // A locked grant holds the address steady while L2 back-pressures.
    always_comb begin
        if (lock_q) begin
            grant = lockedId_q;
        end else if (bus.REQ0_VALID && bus.REQ1_VALID) begin
            grant = ~lastGrant_q;
        end else if (bus.REQ1_VALID) begin
            grant = PORT_DATA;
        end else begin
            grant = PORT_INS;
        end
    end

    assign reqValid         = (bus.REQ0_VALID || bus.REQ1_VALID) && !fifoFull;
    assign reqHandshake     = reqValid && bus.L2_REQ_READY;
    assign bus.L2_REQ_VALID = reqValid;
    assign bus.L2_REQ_ADDR  = (grant == PORT_DATA) ? bus.REQ1_ADDR : bus.REQ0_ADDR;
    assign bus.REQ0_READY   = (grant == PORT_INS)  && bus.L2_REQ_READY && !fifoFull;
    assign bus.REQ1_READY   = (grant == PORT_DATA) && bus.L2_REQ_READY && !fifoFull;

    assign headReady              = (head == PORT_DATA) ? bus.RESP1_READY : bus.RESP0_READY;
    assign dataReady              = !fifoEmpty && headReady;
    assign bus.DATA_FROM_L2_READY = dataReady;
    assign bus.RESP0_VALID        = bus.DATA_FROM_L2_VALID && !fifoEmpty && (head == PORT_INS);
    assign bus.RESP1_VALID        = bus.DATA_FROM_L2_VALID && !fifoEmpty && (head == PORT_DATA);
    assign bus.RESP_DATA          = bus.DATA_FROM_L2;
    assign beatHandshake          = bus.DATA_FROM_L2_VALID && dataReady;
    assign lastBeat               = (beatCnt_q == LAST_BEAT);
    assign bus.RESP_LAST          = lastBeat;
    assign bus.UNEXPECTED_RESP    = unexpected_q;

    outstanding_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .PTR_W (PTR_W)
    ) u_id_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (reqHandshake),
        .pop_i   (beatHandshake && lastBeat),
        .id_i    (grant),
        .head_o  (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    always_comb begin
        lock_d       = lock_q;
        lockedId_d   = lockedId_q;
        lastGrant_d  = lastGrant_q;
        beatCnt_d    = beatCnt_q;
        unexpected_d = unexpected_q;
        if (reqHandshake) begin
            lock_d      = 1'b0;
            lastGrant_d = grant;
        end else if (reqValid) begin
            lock_d     = 1'b1;
            lockedId_d = grant;
        end
        if (beatHandshake) begin
            beatCnt_d = lastBeat ? '0 : beatCnt_q + CNT_W'(1);
        end
        // A beat with nothing outstanding can never be delivered; flag it until reset.
        if (bus.DATA_FROM_L2_VALID && fifoEmpty) begin
            unexpected_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_q       <= 1'b0;
            lockedId_q   <= PORT_INS;
            lastGrant_q  <= PORT_DATA;
            beatCnt_q    <= '0;
            unexpected_q <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lockedId_q   <= lockedId_d;
            lastGrant_q  <= lastGrant_d;
            beatCnt_q    <= beatCnt_d;
            unexpected_q <= unexpected_d;
        end
    end

endmodule
